// File: rtl/data_ram_pkg.sv
// data_ram_pkg: shared FSM state type and default geometry/timing for data_ram.
package data_ram_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_WAIT_CYCLES = 2;
endpackage

// File: rtl/data_ram_if.sv
// data_ram_if: request/response bus between a requester and data_ram.
interface data_ram_if;
    logic ce_i;
    logic we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0] sel_i;
    logic [31:0] data_o;
    logic ready_o;
    modport master(output ce_i, we_i, addr_i, data_i, sel_i, input data_o, ready_o);
    modport slave(input ce_i, we_i, addr_i, data_i, sel_i, output data_o, ready_o);
endinterface

// File: rtl/ram_byte_array.sv
// ram_byte_array: four 8-bit storage lanes with per-lane write enables and a registered read port.
module ram_byte_array import data_ram_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic clk,
    input logic rst,
    input logic re,
    input logic [3:0] we,
    input logic [ADDR_W-1:0] addr,
    input logic [31:0] wdata,
    output logic [31:0] rdata
);
    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] mem [2**ADDR_W];
        logic [7:0] q;
        always_ff @(posedge clk)
            if (we[i]) mem[addr] <= wdata[8*i +: 8];
        // Only the read register clears on reset; stored words survive it.
        always_ff @(posedge clk or negedge rst)
            if (!rst) q <= '0;
            else if (re) q <= mem[addr];
        assign rdata[8*i +: 8] = q;
    end
endmodule

// File: rtl/data_ram.sv
// data_ram: word-addressed RAM with byte-lane writes, programmable wait states and a one-cycle ready strobe.
module data_ram import data_ram_pkg::*; #(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic clk,
    input logic rst,
    data_ram_if.slave bus
);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);
    state_t state;
    logic [3:0] cnt;
    logic ready;
    logic we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0] data_q;
    logic [3:0] sel_q;
    logic take, go, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0] r_data;
    logic [3:0] r_sel;
    logic unused;
    assign take = state == IDLE && bus.ce_i;
    assign go = (take && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd1);
    // With no wait states the access happens on the accepting edge, before the latches hold the request.
    assign r_we = take ? bus.we_i : we_q;
    assign r_addr = take ? bus.addr_i[ADDR_W+1:2] : addr_q;
    assign r_data = take ? bus.data_i : data_q;
    assign r_sel = take ? bus.sel_i : sel_q;
    assign bus.ready_o = ready;
    assign unused = ^{bus.addr_i[31:ADDR_W+2], bus.addr_i[1:0]};
    ram_byte_array #(.ADDR_W(ADDR_W)) u_ram (
        .clk(clk),
        .rst(rst),
        .re(go && !r_we),
        .we(go && r_we ? r_sel : 4'b0000),
        .addr(r_addr),
        .wdata(r_data),
        .rdata(bus.data_o)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt <= '0;
            ready <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            sel_q <= '0;
        end else begin
            ready <= go;
            case (state)
                IDLE: if (bus.ce_i) begin
                    we_q <= bus.we_i;
                    addr_q <= bus.addr_i[ADDR_W+1:2];
                    data_q <= bus.data_i;
                    sel_q <= bus.sel_i;
                    cnt <= WC;
                    state <= WAIT_CYCLES == 0 ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: random and directed checks of data_ram (2 and 0 wait states) against a word-array model.
module tb_data_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errs = 0;
    int rdy_cyc = 0;
    logic [31:0] m2 [1024];
    logic [31:0] m0 [1024];
    logic [31:0] last2, last0;

    data_ram_if bus2();
    data_ram_if bus0();
    data_ram #(.ADDR_W(10), .WAIT_CYCLES(2)) u_w2(.clk(clk), .rst(rst), .bus(bus2.slave));
    data_ram #(.ADDR_W(10), .WAIT_CYCLES(0)) u_w0(.clk(clk), .rst(rst), .bus(bus0.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
        for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = d[8*b +: 8];
        return o;
    endfunction

    function automatic logic rdy(input bit f);
        return f ? bus0.ready_o : bus2.ready_o;
    endfunction

    function automatic logic [31:0] dout(input bit f);
        return f ? bus0.data_o : bus2.data_o;
    endfunction

    function automatic logic [31:0] raddr(input int idx);
        return ($urandom() << 12) | 32'(idx << 2) | ($urandom() & 32'h3);
    endfunction

    task automatic drive(input bit f, input bit ce, input bit we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
        if (f) begin
            bus0.ce_i = ce; bus0.we_i = we; bus0.addr_i = a; bus0.data_i = d; bus0.sel_i = s;
        end else begin
            bus2.ce_i = ce; bus2.we_i = we; bus2.addr_i = a; bus2.data_i = d; bus2.sel_i = s;
        end
    endtask

    task automatic wait_ready(input bit f, output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!rdy(f) && n < 20);
        if (!rdy(f)) check("timeout", 32'd0, 32'd1);
        rdy_cyc = cyc;
    endtask

    task automatic op(input string tag, input bit f, input bit we, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, output logic [31:0] q);
        int n, i;
        logic [31:0] exp;
        i = int'(a[11:2]);
        drive(f, 1'b1, we, a, d, s);
        wait_ready(f, n);
        check({tag, "_lat"}, n, f ? 32'd1 : 32'd3);
        q = dout(f);
        if (we) begin
            if (f) m0[i] = merge(m0[i], d, s);
            else m2[i] = merge(m2[i], d, s);
            check({tag, "_hold"}, q, f ? last0 : last2);
        end else begin
            exp = f ? m0[i] : m2[i];
            check({tag, "_rd"}, q, exp);
            if (f) last0 = exp;
            else last2 = exp;
        end
        drive(f, 1'b0, 1'($urandom()), $urandom(), $urandom(), 4'($urandom()));
        @(posedge clk); #1;
        check({tag, "_pulse"}, 32'(rdy(f)), 32'd0);
    endtask

    initial begin
        logic [31:0] q;
        int c1, n, seen;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        last2 = '0;
        last0 = '0;
        #1 rst = 1'b0;
        #2;
        check("rst_dout2", bus2.data_o, 32'h0);
        check("rst_rdy2", 32'(bus2.ready_o), 32'd0);
        check("rst_dout0", bus0.data_o, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;

        op("w10", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, q);
        op("r10", 0, 0, 32'h10, 32'h0, 4'h0, q);
        check("r10_val", q, 32'hDEADBEEF);

        op("w20a", 0, 1, 32'h20, 32'h11223344, 4'hF, q);
        op("w20b", 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, q);
        op("r20", 0, 0, 32'h20, 32'h0, 4'h0, q);
        check("r20_val", q, 32'h11BB33DD);
        op("w20z", 0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, q);
        op("r20z", 0, 0, 32'h20, 32'h0, 4'hF, q);
        check("r20z_val", q, 32'h11BB33DD);

        op("w30", 0, 1, 32'h30, 32'hCAFEF00D, 4'hF, q);
        c1 = rdy_cyc;
        op("r30", 0, 0, 32'h30, 32'h0, 4'h0, q);
        check("b2b_gap", 32'(rdy_cyc - c1), 32'd4);
        check("r30_val", q, 32'hCAFEF00D);

        op("w44", 0, 1, 32'h44, 32'h55555555, 4'hF, q);
        drive(0, 1'b1, 1'b1, 32'h40, 32'h01234567, 4'hF);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h44, 32'h89ABCDEF, 4'h3);
        wait_ready(0, n);
        check("mid_lat", n, 32'd2);
        m2[16] = 32'h01234567;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk); #1;
        op("r40", 0, 0, 32'h40, 32'h0, 4'h0, q);
        check("r40_val", q, 32'h01234567);
        op("r44", 0, 0, 32'h44, 32'h0, 4'h0, q);

        op("w50", 0, 1, 32'h50, 32'h0BADF00D, 4'hF, q);
        drive(0, 1'b1, 1'b1, 32'h50, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        #1 rst = 1'b0;
        #1;
        check("arst_dout", bus2.data_o, 32'h0);
        check("arst_rdy", 32'(bus2.ready_o), 32'd0);
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus2.ready_o) seen++;
        end
        check("arst_noready", 32'(seen), 32'd0);
        last2 = '0;
        last0 = '0;
        @(negedge clk) rst = 1'b1;
        op("r50", 0, 0, 32'h50, 32'h0, 4'h0, q);
        check("r50_val", q, 32'h0BADF00D);

        for (int i = 0; i < 16; i++) op("pre2", 0, 1, raddr(64 + i), $urandom(), 4'hF, q);
        for (int k = 0; k < 40; k++)
            op("rnd2", 0, 1'($urandom()), raddr(64 + int'($urandom_range(0, 15))), $urandom(), 4'($urandom()), q);

        op("aw", 1, 1, 32'h00001004, 32'h600DCAFE, 4'hF, q);
        op("ar", 1, 0, 32'h00000004, 32'h0, 4'h0, q);
        check("alias_val", q, 32'h600DCAFE);
        for (int i = 0; i < 16; i++) op("pre0", 1, 1, raddr(128 + i), $urandom(), 4'hF, q);
        for (int k = 0; k < 30; k++)
            op("rnd0", 1, 1'($urandom()), raddr(128 + int'($urandom_range(0, 15))), $urandom(), 4'($urandom()), q);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 10, giving the log2 of the word depth (1024 x 32-bit words).
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, range 0..15, giving the wait states inserted before each response.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 ce_i  input  1  request valid; the requester holds it and all request fields stable until ready_o.
REQ-006 we_i  input  1  1 = write, 0 = read.
REQ-007 addr_i  input  32  byte address; bits [ADDR_W+1:2] select the word; all other bits ignored.
REQ-008 data_i  input  32  write data.
REQ-009 sel_i  input  4  byte-lane enables; sel_i[n] covers bits [8n+7:8n].
REQ-010 data_o  output  32  read data; registered.
REQ-011 ready_o  output  1  one-cycle completion strobe for the current request.

Function
REQ-012 The control FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-013 In IDLE with ce_i=1, the block SHALL latch addr_i, we_i, data_i and sel_i, then enter RESP if WAIT_CYCLES=0, otherwise enter WAIT with the counter set to WAIT_CYCLES.
REQ-014 In IDLE with ce_i=0, the FSM SHALL remain in IDLE.
REQ-015 In WAIT, the counter SHALL decrement each cycle, and the FSM SHALL enter RESP on the edge where the counter equals 1.
REQ-016 In RESP, ready_o SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE unconditionally; ready_o SHALL be 0 in all other states.
REQ-017 Latency from the request-accepting edge to ready_o high SHALL be WAIT_CYCLES+1 cycles.
REQ-018 A write SHALL commit on the edge entering RESP, updating only the lanes with a latched sel bit of 1; other lanes SHALL keep their contents.
REQ-019 A write with sel=4'b0000 SHALL change no storage and SHALL still produce ready_o.
REQ-020 A read SHALL load the full addressed word into data_o on the edge entering RESP, ignoring sel.
REQ-021 data_o SHALL hold its value through writes and idle cycles until the next read completes.
REQ-022 ce_i and input changes during WAIT or RESP SHALL be ignored.
REQ-023 A new request MAY be presented in the IDLE cycle immediately after RESP and SHALL be accepted there, giving back-to-back throughput of one request per WAIT_CYCLES+2 cycles.
REQ-024 A read of a word written by the immediately preceding request SHALL return the new data.
REQ-025 Addresses beyond the depth SHALL alias modulo 2^ADDR_W words.

Reset
REQ-026 While rst=0, the block SHALL force state to IDLE, counter to 0, ready_o to 0 and data_o to 32'h0 immediately, without waiting for a clock edge.
REQ-027 Storage contents SHALL NOT be reset.
REQ-028 A reset asserted during WAIT SHALL abort the request, with no write committed and no ready_o.
REQ-029 After rst deasserts, the first request SHALL be accepted on the first edge with ce_i=1.

Structure
REQ-030 A shared package SHALL hold the FSM state enum (IDLE/WAIT/RESP) and the default ADDR_W and WAIT_CYCLES constants.
REQ-031 The storage SHALL be one sub-module, ram_byte_array: four 8-bit lanes with per-lane write enable and a synchronous read port.
REQ-032 The FSM, counter and request latches SHALL reside in data_ram.

Verification
REQ-033 Full-word write, WAIT_CYCLES=2: write 0x0000_0010 <- 0xDEADBEEF with sel=1111 -> ready_o high exactly 3 cycles after acceptance; a read of 0x10 then returns 0xDEADBEEF after another 3 cycles.
REQ-034 Byte lanes: preload 0x11223344 at 0x20, write 0xAABBCCDD with sel=0101 -> a read of 0x20 returns 0x11BB33DD; a write with sel=0000 leaves the word unchanged and still pulses ready_o.
REQ-035 Back-to-back: write 0x30 <- 0xCAFEF00D, then a read of 0x30 presented in the IDLE cycle after ready -> data_o=0xCAFEF00D, with ready pulses 4 cycles apart.
REQ-036 Mid-operation: change addr_i and data_i during WAIT -> the originally latched values are used; assert rst=0 during WAIT -> ready_o never pulses, the target word is unchanged, and data_o=0 asynchronously.
REQ-037 WAIT_CYCLES=0 build: each request gives ready_o on the next cycle; addresses 0x0000_1004 and 0x0000_0004 alias to the same word with ADDR_W=10.
